// File: rtl/udma_hyper_twd_splitter.sv
// Splits one queued HyperBus command into 1D burst descriptors, walking
// row counters and address accumulators for 2D (strided) transfers.
module udma_hyper_twd_splitter #(
  parameter int L2_AWIDTH_NOAL = 12,
  parameter int TRANS_SIZE     = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clr_i,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic [L2_AWIDTH_NOAL-1:0] cmd_l2_addr_i,
  input  logic [31:0]               cmd_hyper_addr_i,
  input  logic [TRANS_SIZE-1:0]     cmd_size_i,
  input  logic                      cmd_rw_i,
  input  logic                      cmd_ext_act_i,
  input  logic [TRANS_SIZE-1:0]     cmd_ext_count_i,
  input  logic [TRANS_SIZE-1:0]     cmd_ext_stride_i,
  input  logic                      cmd_l2_act_i,
  input  logic [TRANS_SIZE-1:0]     cmd_l2_count_i,
  input  logic [TRANS_SIZE-1:0]     cmd_l2_stride_i,
  output logic                      burst_valid_o,
  input  logic                      burst_ready_i,
  output logic [L2_AWIDTH_NOAL-1:0] burst_l2_addr_o,
  output logic [31:0]               burst_hyper_addr_o,
  output logic [TRANS_SIZE-1:0]     burst_size_o,
  output logic                      burst_rw_o,
  output logic                      burst_last_o,
  output logic                      evt_cmd_done_o,
  output logic                      busy_o,
  output logic                      dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are
  // both high and clr_i is low; a pending descriptor holds all fields stable.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

  state_t                    r_state, w_state_next;
  logic [TRANS_SIZE-1:0]     r_rem, w_rem_next;
  logic [TRANS_SIZE-1:0]     r_chunk, w_chunk_next;
  logic                      r_ext_act, w_ext_act_next;
  logic                      r_l2_act, w_l2_act_next;
  logic [TRANS_SIZE-1:0]     r_ext_stride, w_ext_stride_next;
  logic [TRANS_SIZE-1:0]     r_l2_stride, w_l2_stride_next;
  logic                      r_burst_valid, w_burst_valid_next;
  logic [L2_AWIDTH_NOAL-1:0] r_burst_l2, w_burst_l2_next;
  logic [31:0]               r_burst_hyper, w_burst_hyper_next;
  logic [TRANS_SIZE-1:0]     r_burst_size, w_burst_size_next;
  logic                      r_burst_rw, w_burst_rw_next;
  logic                      r_burst_last, w_burst_last_next;
  logic                      r_evt, w_evt_next;

  logic                      w_cmd_hs;
  logic                      w_burst_hs;
  logic [TRANS_SIZE-1:0]     w_cmd_chunk;
  logic [TRANS_SIZE-1:0]     w_rem_after;
  logic [31:0]               w_hyper_step;
  logic [TRANS_SIZE-1:0]     w_l2_step;

  assign w_cmd_hs   = (r_state == ST_IDLE) & cmd_valid_i & ~clr_i;
  assign w_burst_hs = (r_state == ST_ISSUE) & r_burst_valid & burst_ready_i & ~clr_i;

  // A zero row count with its side active degenerates to a single full burst.
  always_comb begin
    w_cmd_chunk = cmd_size_i;
    if (cmd_ext_act_i) begin
      if (cmd_ext_count_i != '0) w_cmd_chunk = cmd_ext_count_i;
    end else if (cmd_l2_act_i) begin
      if (cmd_l2_count_i != '0) w_cmd_chunk = cmd_l2_count_i;
    end
  end

  assign w_rem_after  = r_rem - r_burst_size;
  assign w_hyper_step = r_ext_act ? 32'(r_ext_stride) : 32'(r_burst_size);
  assign w_l2_step    = r_l2_act ? r_l2_stride : r_burst_size;

  always_comb begin
    w_state_next       = r_state;
    w_rem_next         = r_rem;
    w_chunk_next       = r_chunk;
    w_ext_act_next     = r_ext_act;
    w_l2_act_next      = r_l2_act;
    w_ext_stride_next  = r_ext_stride;
    w_l2_stride_next   = r_l2_stride;
    w_burst_valid_next = r_burst_valid;
    w_burst_l2_next    = r_burst_l2;
    w_burst_hyper_next = r_burst_hyper;
    w_burst_size_next  = r_burst_size;
    w_burst_rw_next    = r_burst_rw;
    w_burst_last_next  = r_burst_last;
    w_evt_next         = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_cmd_hs) begin
          w_ext_act_next    = cmd_ext_act_i;
          w_l2_act_next     = cmd_l2_act_i;
          w_ext_stride_next = cmd_ext_stride_i;
          w_l2_stride_next  = cmd_l2_stride_i;
          w_chunk_next      = w_cmd_chunk;
          if (cmd_size_i == '0) begin
            w_evt_next = 1'b1;
          end else begin
            w_state_next       = ST_ISSUE;
            w_rem_next         = cmd_size_i;
            w_burst_valid_next = 1'b1;
            w_burst_l2_next    = cmd_l2_addr_i;
            w_burst_hyper_next = cmd_hyper_addr_i;
            w_burst_rw_next    = cmd_rw_i;
            w_burst_size_next  = (cmd_size_i < w_cmd_chunk) ? cmd_size_i : w_cmd_chunk;
            w_burst_last_next  = (cmd_size_i <= w_cmd_chunk);
          end
        end
      end
      ST_ISSUE: begin
        if (w_burst_hs) begin
          if (r_burst_last) begin
            w_state_next       = ST_IDLE;
            w_burst_valid_next = 1'b0;
            w_evt_next         = 1'b1;
          end else begin
            w_rem_next         = w_rem_after;
            w_burst_hyper_next = r_burst_hyper + w_hyper_step;
            w_burst_l2_next    = r_burst_l2 + L2_AWIDTH_NOAL'(w_l2_step);
            w_burst_size_next  = (w_rem_after < r_chunk) ? w_rem_after : r_chunk;
            w_burst_last_next  = (w_rem_after <= r_chunk);
          end
        end
      end
      default: begin
        w_state_next       = ST_IDLE;
        w_burst_valid_next = 1'b0;
      end
    endcase

    // Abort wins over any handshake in the same cycle and suppresses the done event.
    if (clr_i) begin
      w_state_next       = ST_IDLE;
      w_burst_valid_next = 1'b0;
      w_evt_next         = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state       <= ST_IDLE;
      r_rem         <= '0;
      r_chunk       <= '0;
      r_ext_act     <= 1'b0;
      r_l2_act      <= 1'b0;
      r_ext_stride  <= '0;
      r_l2_stride   <= '0;
      r_burst_valid <= 1'b0;
      r_burst_l2    <= '0;
      r_burst_hyper <= '0;
      r_burst_size  <= '0;
      r_burst_rw    <= 1'b0;
      r_burst_last  <= 1'b0;
      r_evt         <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_rem         <= w_rem_next;
      r_chunk       <= w_chunk_next;
      r_ext_act     <= w_ext_act_next;
      r_l2_act      <= w_l2_act_next;
      r_ext_stride  <= w_ext_stride_next;
      r_l2_stride   <= w_l2_stride_next;
      r_burst_valid <= w_burst_valid_next;
      r_burst_l2    <= w_burst_l2_next;
      r_burst_hyper <= w_burst_hyper_next;
      r_burst_size  <= w_burst_size_next;
      r_burst_rw    <= w_burst_rw_next;
      r_burst_last  <= w_burst_last_next;
      r_evt         <= w_evt_next;
    end
  end

  assign cmd_ready_o        = w_cmd_hs;
  assign burst_valid_o      = r_burst_valid;
  assign burst_l2_addr_o    = r_burst_l2;
  assign burst_hyper_addr_o = r_burst_hyper;
  assign burst_size_o       = r_burst_size;
  assign burst_rw_o         = r_burst_rw;
  assign burst_last_o       = r_burst_last;
  assign evt_cmd_done_o     = r_evt;
  assign busy_o             = (r_state != ST_IDLE);
  assign dbg_state_o        = r_state;

endmodule

// File: tb/tb_udma_hyper_twd_splitter.sv
// Bench for udma_hyper_twd_splitter: command table plus hand-written corner
// sequences, bursts checked against an expected-descriptor queue.
module tb_udma_hyper_twd_splitter;

  localparam int DW = 62;

  typedef struct {
    logic [15:0] size;
    logic [31:0] hyper;
    logic [11:0] l2;
    logic        rw;
    logic        ext_act;
    logic [15:0] ext_cnt;
    logic [15:0] ext_str;
    logic        l2_act;
    logic [15:0] l2_cnt;
    logic [15:0] l2_str;
    int          nb;
  } vec_t;

  logic        clk;
  logic        rst_ni;
  logic        clr_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [11:0] cmd_l2_addr_i;
  logic [31:0] cmd_hyper_addr_i;
  logic [15:0] cmd_size_i;
  logic        cmd_rw_i;
  logic        cmd_ext_act_i;
  logic [15:0] cmd_ext_count_i;
  logic [15:0] cmd_ext_stride_i;
  logic        cmd_l2_act_i;
  logic [15:0] cmd_l2_count_i;
  logic [15:0] cmd_l2_stride_i;
  logic        burst_valid_o;
  logic        burst_ready_i;
  logic [11:0] burst_l2_addr_o;
  logic [31:0] burst_hyper_addr_o;
  logic [15:0] burst_size_o;
  logic        burst_rw_o;
  logic        burst_last_o;
  logic        evt_cmd_done_o;
  logic        busy_o;
  logic        dbg_state_o;

  logic [DW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int burst_cnt = 0;
  int evt_cnt   = 0;
  int ready_mode = 0;
  logic manual_ready = 1'b0;
  logic [31:0] ready_pat = '1;
  logic prev_stall = 1'b0;
  logic [DW-1:0] prev_desc = '0;

  udma_hyper_twd_splitter #(.L2_AWIDTH_NOAL(12), .TRANS_SIZE(16)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .clr_i(clr_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_l2_addr_i(cmd_l2_addr_i), .cmd_hyper_addr_i(cmd_hyper_addr_i),
    .cmd_size_i(cmd_size_i), .cmd_rw_i(cmd_rw_i),
    .cmd_ext_act_i(cmd_ext_act_i), .cmd_ext_count_i(cmd_ext_count_i),
    .cmd_ext_stride_i(cmd_ext_stride_i), .cmd_l2_act_i(cmd_l2_act_i),
    .cmd_l2_count_i(cmd_l2_count_i), .cmd_l2_stride_i(cmd_l2_stride_i),
    .burst_valid_o(burst_valid_o), .burst_ready_i(burst_ready_i),
    .burst_l2_addr_o(burst_l2_addr_o), .burst_hyper_addr_o(burst_hyper_addr_o),
    .burst_size_o(burst_size_o), .burst_rw_o(burst_rw_o),
    .burst_last_o(burst_last_o), .evt_cmd_done_o(evt_cmd_done_o),
    .busy_o(busy_o), .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pk(input logic [31:0] h, input logic [11:0] l,
                                       input logic [15:0] s, input logic rw, input logic last);
    return {h, l, s, rw, last};
  endfunction

  function automatic vec_t mk(input logic [15:0] size, input logic [31:0] hyper,
                              input logic [11:0] l2, input logic rw,
                              input logic ext_act, input logic [15:0] ext_cnt, input logic [15:0] ext_str,
                              input logic l2_act, input logic [15:0] l2_cnt, input logic [15:0] l2_str,
                              input int nb);
    vec_t v;
    v.size = size; v.hyper = hyper; v.l2 = l2; v.rw = rw;
    v.ext_act = ext_act; v.ext_cnt = ext_cnt; v.ext_str = ext_str;
    v.l2_act = l2_act; v.l2_cnt = l2_cnt; v.l2_str = l2_str; v.nb = nb;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: walk rows of the transfer and queue every expected descriptor.
  task automatic model_push(input vec_t v);
    logic [31:0] h;
    logic [11:0] l;
    logic [15:0] rem, ch, bs;
    h = v.hyper; l = v.l2; rem = v.size;
    if (v.ext_act) ch = (v.ext_cnt != 0) ? v.ext_cnt : v.size;
    else if (v.l2_act) ch = (v.l2_cnt != 0) ? v.l2_cnt : v.size;
    else ch = v.size;
    while (rem != 0) begin
      bs = (rem < ch) ? rem : ch;
      exp_q.push_back(pk(h, l, bs, v.rw, rem <= ch));
      h = h + (v.ext_act ? {16'h0, v.ext_str} : {16'h0, bs});
      l = l + (v.l2_act ? v.l2_str[11:0] : bs[11:0]);
      rem = rem - bs;
    end
  endtask

  // burst_ready driver
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: burst_ready_i = 1'b1;
      1: burst_ready_i = ($urandom_range(0, 3) != 0);
      2: burst_ready_i = manual_ready;
      default: begin
        if (burst_valid_o) begin
          burst_ready_i = ready_pat[0];
          ready_pat = {1'b1, ready_pat[31:1]};
        end else begin
          burst_ready_i = 1'b0;
        end
      end
    endcase
  end

  // scoreboard monitor
  always @(negedge clk) begin
    logic [DW-1:0] w;
    w = pk(burst_hyper_addr_o, burst_l2_addr_o, burst_size_o, burst_rw_o, burst_last_o);
    if (rst_ni) begin
      if (prev_stall) begin
        check("stall_valid_held", {63'h0, burst_valid_o}, 64'h1);
        check("stall_desc_held", {2'b0, w}, {2'b0, prev_desc});
      end
      if (burst_valid_o && burst_ready_i && !clr_i) begin
        burst_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_burst: got %h expected none", w);
        end else begin
          check("burst_desc", {2'b0, w}, {2'b0, exp_q.pop_front()});
        end
      end
      if (evt_cmd_done_o) evt_cnt++;
      prev_stall = burst_valid_o && !burst_ready_i && !clr_i;
      prev_desc = w;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // driver: present a command and return in the cycle after acceptance
  task automatic send_cmd(input vec_t v);
    int n;
    @(posedge clk); #1;
    cmd_size_i = v.size; cmd_hyper_addr_i = v.hyper; cmd_l2_addr_i = v.l2;
    cmd_rw_i = v.rw; cmd_ext_act_i = v.ext_act; cmd_ext_count_i = v.ext_cnt;
    cmd_ext_stride_i = v.ext_str; cmd_l2_act_i = v.l2_act;
    cmd_l2_count_i = v.l2_cnt; cmd_l2_stride_i = v.l2_str;
    cmd_valid_i = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_ready_o && n < 100);
    check("cmd_accept", {63'h0, cmd_ready_o}, 64'h1);
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
  endtask

  task automatic run_cmd(input vec_t v, input bit use_model);
    int n, b0, e0;
    if (use_model) model_push(v);
    b0 = burst_cnt;
    e0 = evt_cnt;
    send_cmd(v);
    n = 0;
    while (evt_cnt == e0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("evt_seen", 64'(evt_cnt - e0), 64'd1);
    check("burst_count", 64'(burst_cnt - b0), 64'(v.nb));
    check("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  vec_t tbl[12];
  vec_t v;

  initial begin
    tbl[0]  = mk(16'd64,  32'h0000_2000, 12'h010, 1'b0, 1'b0, 16'd0,  16'd0,   1'b0, 16'd0,  16'd0,  1);
    tbl[1]  = mk(16'd64,  32'h0000_1000, 12'h100, 1'b1, 1'b1, 16'd16, 16'd256, 1'b0, 16'd0,  16'd0,  4);
    tbl[2]  = mk(16'd40,  32'h0000_1000, 12'h100, 1'b0, 1'b0, 16'd0,  16'd0,   1'b1, 16'd16, 16'd64, 3);
    tbl[3]  = mk(16'd25,  32'h0000_4000, 12'h200, 1'b1, 1'b1, 16'd10, 16'd100, 1'b1, 16'd7,  16'd50, 3);
    tbl[4]  = mk(16'd30,  32'h0000_5000, 12'h300, 1'b0, 1'b1, 16'd0,  16'd64,  1'b0, 16'd0,  16'd0,  1);
    tbl[5]  = mk(16'd5,   32'h0000_6000, 12'h040, 1'b1, 1'b0, 16'd0,  16'd0,   1'b1, 16'd16, 16'd32, 1);
    tbl[6]  = mk(16'd6,   32'h0000_7000, 12'h050, 1'b0, 1'b1, 16'd1,  16'd4,   1'b0, 16'd0,  16'd0,  6);
    tbl[7]  = mk(16'd48,  32'hFFFF_FFE0, 12'h060, 1'b1, 1'b1, 16'd16, 16'd16,  1'b0, 16'd0,  16'd0,  3);
    tbl[8]  = mk(16'd48,  32'h0000_8000, 12'hFF0, 1'b0, 1'b0, 16'd0,  16'd0,   1'b1, 16'd16, 16'd16, 3);
    tbl[9]  = mk(16'd0,   32'h0000_9000, 12'h070, 1'b1, 1'b1, 16'd16, 16'd16,  1'b0, 16'd0,  16'd0,  0);
    tbl[10] = mk(16'd33,  32'h0000_A000, 12'h080, 1'b0, 1'b0, 16'd0,  16'd0,   1'b1, 16'd0,  16'd64, 1);
    tbl[11] = mk(16'd100, 32'h0000_B000, 12'h090, 1'b1, 1'b1, 16'd32, 16'd512, 1'b0, 16'd0,  16'd0,  4);

    rst_ni = 1'b0; clr_i = 1'b0; cmd_valid_i = 1'b0; burst_ready_i = 1'b1;
    cmd_l2_addr_i = '0; cmd_hyper_addr_i = '0; cmd_size_i = '0; cmd_rw_i = 1'b0;
    cmd_ext_act_i = 1'b0; cmd_ext_count_i = '0; cmd_ext_stride_i = '0;
    cmd_l2_act_i = 1'b0; cmd_l2_count_i = '0; cmd_l2_stride_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", {63'h0, cmd_ready_o}, 64'h0);
    check("rst_burst_valid", {63'h0, burst_valid_o}, 64'h0);
    check("rst_outputs", {2'b0, pk(burst_hyper_addr_o, burst_l2_addr_o, burst_size_o, burst_rw_o, burst_last_o)}, 64'h0);
    check("rst_evt_busy", {62'h0, evt_cmd_done_o, busy_o}, 64'h0);
    @(posedge clk); #1 rst_ni = 1'b1;

    // 1D pass-through with exact latency
    v = mk(16'd64, 32'h0000_1000, 12'h100, 1'b1, 1'b0, 16'd0, 16'd0, 1'b0, 16'd0, 16'd0, 1);
    exp_q.push_back(pk(32'h0000_1000, 12'h100, 16'd64, 1'b1, 1'b1));
    send_cmd(v);
    @(negedge clk);
    check("1d_valid_n1", {62'h0, burst_valid_o, evt_cmd_done_o}, 64'h2);
    check("1d_busy_n1", {63'h0, busy_o}, 64'h1);
    @(negedge clk);
    check("1d_evt_n2", {62'h0, burst_valid_o, evt_cmd_done_o}, 64'h1);
    check("1d_idle_n2", {62'h0, busy_o, dbg_state_o}, 64'h0);
    check("1d_queue", 64'(exp_q.size()), 64'd0);

    // zero-size command: done pulse, no burst
    v = mk(16'd0, 32'h0000_1000, 12'h100, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 16'd0, 16'd0, 0);
    send_cmd(v);
    @(negedge clk);
    check("size0_evt", {61'h0, evt_cmd_done_o, burst_valid_o, busy_o}, 64'h4);
    @(negedge clk);
    check("size0_evt_pulse", {62'h0, evt_cmd_done_o, burst_valid_o}, 64'h0);

    // 2D external side with 5-cycle stall after the first burst
    @(negedge clk);
    ready_pat = 32'hFFFF_FFC1;
    ready_mode = 3;
    v = mk(16'd64, 32'h0000_1000, 12'h100, 1'b1, 1'b1, 16'd16, 16'd256, 1'b0, 16'd0, 16'd0, 4);
    for (int i = 0; i < 4; i++)
      exp_q.push_back(pk(32'h0000_1000 + 32'(i) * 32'h100, 12'h100 + 12'(i) * 12'h10, 16'd16, 1'b1, i == 3));
    run_cmd(v, 1'b0);
    ready_mode = 0;

    // remainder row on the L2 side
    v = mk(16'd40, 32'h0000_1000, 12'h100, 1'b0, 1'b0, 16'd0, 16'd0, 1'b1, 16'd16, 16'd64, 3);
    exp_q.push_back(pk(32'h0000_1000, 12'h100, 16'd16, 1'b0, 1'b0));
    exp_q.push_back(pk(32'h0000_1010, 12'h140, 16'd16, 1'b0, 1'b0));
    exp_q.push_back(pk(32'h0000_1020, 12'h180, 16'd8,  1'b0, 1'b1));
    run_cmd(v, 1'b0);

    // HyperBus address wrap
    v = mk(16'd32, 32'hFFFF_FFF0, 12'h100, 1'b1, 1'b1, 16'd16, 16'd16, 1'b0, 16'd0, 16'd0, 2);
    exp_q.push_back(pk(32'hFFFF_FFF0, 12'h100, 16'd16, 1'b1, 1'b0));
    exp_q.push_back(pk(32'h0000_0000, 12'h110, 16'd16, 1'b1, 1'b1));
    run_cmd(v, 1'b0);

    // abort during the second of four bursts, clr colliding with a handshake
    @(negedge clk);
    ready_mode = 2;
    manual_ready = 1'b0;
    v = mk(16'd64, 32'h0000_3000, 12'h200, 1'b0, 1'b1, 16'd16, 16'd256, 1'b0, 16'd0, 16'd0, 4);
    for (int i = 0; i < 4; i++)
      exp_q.push_back(pk(32'h0000_3000 + 32'(i) * 32'h100, 12'h200 + 12'(i) * 12'h10, 16'd16, 1'b0, i == 3));
    send_cmd(v);
    @(negedge clk);
    check("abort_first_valid", {63'h0, burst_valid_o}, 64'h1);
    manual_ready = 1'b1;
    @(negedge clk);
    manual_ready = 1'b0;
    @(negedge clk);
    check("abort_second_addr", {32'h0, burst_hyper_addr_o}, 64'h3100);
    manual_ready = 1'b1;
    @(posedge clk); #1 clr_i = 1'b1;
    @(posedge clk); #1 clr_i = 1'b0;
    @(negedge clk);
    check("abort_dropped", {60'h0, burst_valid_o, busy_o, evt_cmd_done_o, dbg_state_o}, 64'h0);
    @(negedge clk);
    check("abort_no_evt", {63'h0, evt_cmd_done_o}, 64'h0);
    check("abort_bursts_left", 64'(exp_q.size()), 64'd3);
    exp_q.delete();
    ready_mode = 0;
    run_cmd(tbl[1], 1'b1);

    // asynchronous reset mid-command
    @(negedge clk);
    ready_mode = 2;
    manual_ready = 1'b0;
    send_cmd(tbl[11]);
    #2 rst_ni = 1'b0;
    #1;
    check("arst_valid_busy", {62'h0, burst_valid_o, busy_o}, 64'h0);
    check("arst_desc", {2'b0, pk(burst_hyper_addr_o, burst_l2_addr_o, burst_size_o, burst_rw_o, burst_last_o)}, 64'h0);
    @(posedge clk); #1 rst_ni = 1'b1;
    @(negedge clk);
    ready_mode = 0;

    // table: always-ready, then random backpressure
    for (int i = 0; i < 12; i++) run_cmd(tbl[i], 1'b1);
    @(negedge clk);
    ready_mode = 1;
    for (int i = 0; i < 12; i++) run_cmd(tbl[i], 1'b1);
    ready_mode = 0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
